alu_ctrl_top: RTL

ALU_CTRL_TOP -- requirements
Module: alu_ctrl_top

---
 rtl/alu_ctrl_top.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_top.sv
// alu_ctrl_top: button-driven ALU controller.
// Operands A, B and the opcode are captured from i_sw on rising edges of
// their load buttons. Once all three are loaded, a small FSM
// (IDLE -> EXEC -> DONE) computes and registers the result and flags.
// Optional feature macro: ALU_CTRL_FLAGS_EN (enables the zero/neg/ovf flags).
module alu_ctrl_top #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_carry,
  output logic               o_zero,
  output logic               o_neg,
  output logic               o_ovf,
  output logic               o_valid,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned MSB    = NB_DATA - 1;
  localparam int unsigned NB_CMP = (NB_OP > 6) ? NB_OP : 6;

  localparam logic [NB_CMP-1:0] C_ADD = NB_CMP'(6'b100000);
  localparam logic [NB_CMP-1:0] C_SUB = NB_CMP'(6'b100010);
  localparam logic [NB_CMP-1:0] C_AND = NB_CMP'(6'b100100);
  localparam logic [NB_CMP-1:0] C_OR  = NB_CMP'(6'b100101);
  localparam logic [NB_CMP-1:0] C_XOR = NB_CMP'(6'b100110);
  localparam logic [NB_CMP-1:0] C_NOR = NB_CMP'(6'b100111);
  localparam logic [NB_CMP-1:0] C_SRL = NB_CMP'(6'b000010);
  localparam logic [NB_CMP-1:0] C_SRA = NB_CMP'(6'b000011);

  state_t               state_q, state_n;
  logic [NB_DATA-1:0]   a_q, b_q;
  logic [NB_OP-1:0]     op_q;
  logic [2:0]           mask_q;
  logic [2:0]           btn_q;
  logic                 armed_q;

  logic [2:0]           btn_c, rise_c, win_c;
  logic [NB_CMP-1:0]    op_ext_c;
  logic [NB_DATA:0]     sum_c, diff_c;
  logic [NB_DATA-1:0]   res_c;
  logic                 carry_c, zero_c, neg_c, ovf_c;

  // Rising-edge detect; armed_q masks the first cycle so buttons held through reset are ignored
  always_comb begin
    btn_c  = {i_btn_op, i_btn_b, i_btn_a};
    rise_c = btn_c & ~btn_q & {3{armed_q}};
    win_c  = 3'b000;
    if (rise_c[0])      win_c = 3'b001;
    else if (rise_c[1]) win_c = 3'b010;
    else if (rise_c[2]) win_c = 3'b100;
  end

  // Edge registers, operand/opcode capture and loaded mask
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      armed_q <= 1'b0;
      btn_q   <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      mask_q  <= 3'b000;
    end else begin
      armed_q <= 1'b1;
      btn_q   <= btn_c;
      if (win_c[0]) a_q  <= i_sw;
      if (win_c[1]) b_q  <= i_sw;
      if (win_c[2]) op_q <= i_sw[NB_OP-1:0];
      mask_q <= mask_q | win_c;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (mask_q == 3'b111) state_n = EXEC;
      EXEC:    state_n = DONE;
      DONE:    if (|win_c) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ALU datapath: result and carry/borrow
  always_comb begin
    op_ext_c = NB_CMP'(op_q);
    sum_c    = {1'b0, a_q} + {1'b0, b_q};
    diff_c   = {1'b0, a_q} - {1'b0, b_q};
    res_c    = '0;
    carry_c  = 1'b0;
    case (op_ext_c)
      C_ADD: begin res_c = sum_c[MSB:0];  carry_c = sum_c[NB_DATA];  end
      C_SUB: begin res_c = diff_c[MSB:0]; carry_c = diff_c[NB_DATA]; end
      C_AND: res_c = a_q & b_q;
      C_OR:  res_c = a_q | b_q;
      C_XOR: res_c = a_q ^ b_q;
      C_NOR: res_c = ~(a_q | b_q);
      C_SRL: begin
        if (b_q >= NB_DATA'(NB_DATA)) res_c = '0;
        else                          res_c = a_q >> b_q;
      end
      C_SRA: begin
        if (b_q >= NB_DATA'(NB_DATA)) res_c = {NB_DATA{a_q[MSB]}};
        else                          res_c = NB_DATA'($signed(a_q) >>> b_q);
      end
      default: res_c = '0;
    endcase
  end

  // Optional status flags; tied low when the feature is disabled
  always_comb begin
    zero_c = 1'b0;
    neg_c  = 1'b0;
    ovf_c  = 1'b0;
`ifdef ALU_CTRL_FLAGS_EN
    zero_c = (res_c == '0);
    neg_c  = res_c[MSB];
    if (op_ext_c == C_ADD)
      ovf_c = (a_q[MSB] == b_q[MSB]) && (sum_c[MSB] != a_q[MSB]);
    else if (op_ext_c == C_SUB)
      ovf_c = (a_q[MSB] != b_q[MSB]) && (diff_c[MSB] != a_q[MSB]);
`endif
  end

  // Output registers: result/flags captured on EXEC->DONE, valid for all of DONE
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_result <= '0;
      o_carry  <= 1'b0;
      o_zero   <= 1'b0;
      o_neg    <= 1'b0;
      o_ovf    <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= (state_n == DONE);
      if (state_q == EXEC) begin
        o_result <= res_c;
        o_carry  <= carry_c;
        o_zero   <= zero_c;
        o_neg    <= neg_c;
        o_ovf    <= ovf_c;
      end
    end
  end

  assign o_state = state_q;

endmodule
